// File: rtl/drp_multi_arbiter.sv
// ============================================================================
// Module   : drp_multi_arbiter
// Purpose  : Per-GT-channel DRP arbiter. Each channel queues one request per
//            master, grants round-robin, and holds the grant until the GT
//            returns drprdy or a timeout aborts the transaction.
// Options  : `define DRP_ARB_STATS_EN enables the trans_cnt_o / tmo_cnt_o
//            counters; without it those ports are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module drp_multi_arbiter #(
  parameter int N_CHANNELS     = 2,
  parameter int N_MASTERS      = 2,
  parameter int ADDR_W         = 9,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                                  clk_sys_i,
  input  logic                                  rst_n_i,
  input  logic [N_CHANNELS*N_MASTERS-1:0]        m_drpen_i,
  input  logic [N_CHANNELS*N_MASTERS-1:0]        m_drpwe_i,
  input  logic [N_CHANNELS*N_MASTERS*ADDR_W-1:0] m_drpaddr_i,
  input  logic [N_CHANNELS*N_MASTERS*DATA_W-1:0] m_drpdi_i,
  output logic [N_CHANNELS*N_MASTERS-1:0]        m_drprdy_o,
  output logic [N_CHANNELS*N_MASTERS*DATA_W-1:0] m_drpdo_o,
  output logic [N_CHANNELS-1:0]                  gt_drpen_o,
  output logic [N_CHANNELS-1:0]                  gt_drpwe_o,
  output logic [N_CHANNELS*ADDR_W-1:0]           gt_drpaddr_o,
  output logic [N_CHANNELS*DATA_W-1:0]           gt_drpdi_o,
  input  logic [N_CHANNELS-1:0]                  gt_drprdy_i,
  input  logic [N_CHANNELS*DATA_W-1:0]           gt_drpdo_i,
  output logic [N_CHANNELS-1:0]                  busy_o,
  output logic [N_CHANNELS-1:0]                  timeout_o,
  output logic [N_CHANNELS*2-1:0]                err_sticky_o,
  output logic [N_CHANNELS*16-1:0]               trans_cnt_o,
  output logic [N_CHANNELS*8-1:0]                tmo_cnt_o
);

  localparam int              PTR_W    = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_MASTERS - 1);
  localparam logic [15:0]     TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  generate
    for (genvar c = 0; c < N_CHANNELS; c++) begin : g_chan

      state_t                state;
      state_t                state_nxt;
      logic [N_MASTERS-1:0]  strobe;
      logic [N_MASTERS-1:0]  pend;
      logic [N_MASTERS-1:0]  ovf_hit;
      logic [N_MASTERS-1:0]  req_we;
      logic [ADDR_W-1:0]     req_addr [N_MASTERS];
      logic [DATA_W-1:0]     req_di   [N_MASTERS];
      logic [PTR_W-1:0]      ptr;
      logic [PTR_W-1:0]      sel;
      logic                  found;
      logic                  issue;
      logic                  done_rdy;
      logic                  done_tmo;
      logic [15:0]           tmo_cnt;
      logic                  en_q;
      logic                  we_q;
      logic [ADDR_W-1:0]     addr_q;
      logic [DATA_W-1:0]     di_q;
      logic                  timeout_q;
      logic                  err_tmo;
      logic                  err_ovf;
      logic [DATA_W-1:0]     gt_do;

      assign strobe = m_drpen_i[c*N_MASTERS +: N_MASTERS];
      assign gt_do  = gt_drpdo_i[c*DATA_W +: DATA_W];

      // Per-master request slot and completion outputs
      for (genvar m = 0; m < N_MASTERS; m++) begin : g_mst
        localparam int S = c*N_MASTERS + m;

        logic              pend_r;
        logic              we_r;
        logic [ADDR_W-1:0] addr_r;
        logic [DATA_W-1:0] di_r;
        logic              rdy_r;
        logic [DATA_W-1:0] do_r;
        logic              hit;

        assign hit        = (ptr == PTR_W'(m));
        assign ovf_hit[m] = strobe[m] & pend_r;

        // Capture a request into the free slot; retire it and answer the master on completion
        always_ff @(posedge clk_sys_i) begin
          if (!rst_n_i) begin
            pend_r <= 1'b0;
            we_r   <= 1'b0;
            addr_r <= '0;
            di_r   <= '0;
            rdy_r  <= 1'b0;
            do_r   <= '0;
          end else begin
            rdy_r <= 1'b0;
            if (hit && (done_rdy || done_tmo)) begin
              pend_r <= 1'b0;
              rdy_r  <= 1'b1;
              do_r   <= done_rdy ? gt_do : '0;
            end
            // A strobe into an occupied slot is dropped; the first request stays
            if (strobe[m] && !pend_r) begin
              pend_r <= 1'b1;
              we_r   <= m_drpwe_i[S];
              addr_r <= m_drpaddr_i[S*ADDR_W +: ADDR_W];
              di_r   <= m_drpdi_i[S*DATA_W +: DATA_W];
            end
          end
        end

        assign pend[m]     = pend_r;
        assign req_we[m]   = we_r;
        assign req_addr[m] = addr_r;
        assign req_di[m]   = di_r;

        assign m_drprdy_o[S]                  = rdy_r;
        assign m_drpdo_o[S*DATA_W +: DATA_W]  = do_r;
      end

      // Round-robin search: first pending master after the last granted one, with wrap
      always_comb begin
        logic [PTR_W-1:0] idx;
        found = 1'b0;
        sel   = ptr;
        idx   = ptr;
        for (int i = 0; i < N_MASTERS; i++) begin
          idx = (idx == PTR_LAST) ? '0 : idx + PTR_W'(1);
          if (!found && pend[idx]) begin
            found = 1'b1;
            sel   = idx;
          end
        end
      end

      // FSM state register
      always_ff @(posedge clk_sys_i) begin
        if (!rst_n_i) begin
          state <= ST_IDLE;
        end else begin
          state <= state_nxt;
        end
      end

      // FSM next state and transaction events; GT rdy wins over a same-cycle timeout
      always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        done_rdy  = 1'b0;
        done_tmo  = 1'b0;
        case (state)
          ST_IDLE: begin
            if (found) begin
              issue     = 1'b1;
              state_nxt = ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (gt_drprdy_i[c]) begin
              done_rdy  = 1'b1;
              state_nxt = ST_IDLE;
            end else if (tmo_cnt == TMO_LAST) begin
              done_tmo  = 1'b1;
              state_nxt = ST_IDLE;
            end
          end
          default: state_nxt = ST_IDLE;
        endcase
      end

      // GT-side outputs, grant pointer, timeout counter and sticky errors
      always_ff @(posedge clk_sys_i) begin
        if (!rst_n_i) begin
          en_q      <= 1'b0;
          we_q      <= 1'b0;
          addr_q    <= '0;
          di_q      <= '0;
          ptr       <= PTR_LAST;
          tmo_cnt   <= '0;
          timeout_q <= 1'b0;
          err_tmo   <= 1'b0;
          err_ovf   <= 1'b0;
        end else begin
          en_q      <= issue;
          timeout_q <= done_tmo;
          if (issue) begin
            we_q    <= req_we[sel];
            addr_q  <= req_addr[sel];
            di_q    <= req_di[sel];
            ptr     <= sel;
            tmo_cnt <= '0;
          end else if (state == ST_WAIT) begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
          if (done_tmo) begin
            err_tmo <= 1'b1;
          end
          if (|ovf_hit) begin
            err_ovf <= 1'b1;
          end
        end
      end

      assign gt_drpen_o[c]                   = en_q;
      assign gt_drpwe_o[c]                   = we_q;
      assign gt_drpaddr_o[c*ADDR_W +: ADDR_W] = addr_q;
      assign gt_drpdi_o[c*DATA_W +: DATA_W]   = di_q;
      assign busy_o[c]                       = (state == ST_WAIT);
      assign timeout_o[c]                    = timeout_q;
      assign err_sticky_o[c*2 +: 2]          = {err_ovf, err_tmo};

`ifdef DRP_ARB_STATS_EN
      logic [15:0] trans_q;
      logic [7:0]  tmoc_q;

      // Completion counter wraps; timeout counter saturates
      always_ff @(posedge clk_sys_i) begin
        if (!rst_n_i) begin
          trans_q <= '0;
          tmoc_q  <= '0;
        end else begin
          if (done_rdy || done_tmo) begin
            trans_q <= trans_q + 16'd1;
          end
          if (done_tmo && (tmoc_q != 8'hFF)) begin
            tmoc_q <= tmoc_q + 8'd1;
          end
        end
      end

      assign trans_cnt_o[c*16 +: 16] = trans_q;
      assign tmo_cnt_o[c*8 +: 8]     = tmoc_q;
`else
      assign trans_cnt_o[c*16 +: 16] = '0;
      assign tmo_cnt_o[c*8 +: 8]     = '0;
`endif

    end
  endgenerate

endmodule

`default_nettype wire
